aha_clk_div_ctrl: RTL and testbench
===================================

AHA_CLK_DIV_CTRL -- requirements
Module: aha_clk_div_ctrl

Interface
REQ-001 SHALL have parameter RESET_DIV, default 3'b000, meaning the divide code driven on DIV_OUT after reset.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2, meaning the cycles waited after a generator restart before completion (range 1..15).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the maximum cycles waited for an enable boundary (range 2..64).
REQ-004 SHALL have port CLK_IN, input, 1, clock.
REQ-005 SHALL have port RESETn, input, 1, reset (asynchronous, active-low).
REQ-006 SHALL have port REQ_VALID, input, 1, meaning a divide-change request is pending.
REQ-007 SHALL have port REQ_DIV, input, 3, meaning the requested divide code.
REQ-008 SHALL have port REQ_READY, output, 1, meaning the controller accepts a request.
REQ-009 SHALL have port ACK, output, 1, meaning a one-cycle completion pulse.
REQ-010 SHALL have port DIV_OUT, output, 3, meaning the divide code driven to the clock-enable generator.
REQ-011 SHALL have port GEN_RESETn, output, 1, meaning the active-low restart to the clock-enable generator.
REQ-012 SHALL have port CLK_EN_IN, input, 1, meaning the enable pulse from the generator.
REQ-013 SHALL have port CLK_EN_OUT, output, 1, meaning the masked enable delivered to downstream logic.
REQ-014 SHALL have port TIMEOUT_CLR, input, 1, meaning clear the sticky timeout flag.
REQ-015 SHALL have port TIMEOUT_STICKY, output, 1, meaning a switch was forced by timeout.

Function
REQ-016 SHALL implement states IDLE, WAIT, SWITCH, SETTLE and DONE, all transitions occurring on the rising edge of CLK_IN.
REQ-017 SHALL drive REQ_READY=1 only in IDLE; a request is accepted on an edge where REQ_VALID=1 and REQ_READY=1, and REQ_VALID in any other state is ignored.
REQ-018 SHALL clamp the accepted REQ_DIV values 6 and 7 to 5 when capturing the target.
REQ-019 SHALL go from IDLE to DONE when the captured target equals DIV_OUT, and to WAIT otherwise.
REQ-020 SHALL go from WAIT to SWITCH on the first edge at which CLK_EN_IN=1, with the wait counter starting at 0 on WAIT entry.
REQ-021 SHALL load DIV_OUT with the target on the edge entering SWITCH; DIV_OUT SHALL change at no other time except reset.
REQ-022 SHALL drive GEN_RESETn low for exactly the one cycle spent in SWITCH (registered output, glitch-free).
REQ-023 SHALL go from SWITCH to SETTLE, stay in SETTLE for exactly SETTLE_CYCLES cycles, and then go to DONE.
REQ-024 SHALL hold ACK=1 for the single cycle spent in DONE and then return to IDLE; request-to-ACK latency is 2 cycles when no change is needed.
REQ-025 SHALL set CLK_EN_OUT equal to CLK_EN_IN in IDLE, WAIT and DONE, and force it to 0 in SWITCH and SETTLE.
REQ-026 SHALL, when TIMEOUT_CLR=1, clear TIMEOUT_STICKY on the next edge; if a set and a clear occur on the same edge, the set SHALL win.

Reset
REQ-027 SHALL, on RESETn low, immediately force state IDLE, DIV_OUT=RESET_DIV, GEN_RESETn=1, ACK=0, REQ_READY=1 and TIMEOUT_STICKY=0, and clear all counters.
REQ-028 SHALL, when reset is asserted mid-sequence, abandon the sequence with no ACK, and DIV_OUT SHALL return to RESET_DIV.
REQ-029 SHALL derive CLK_EN_OUT combinationally from state, so that it follows CLK_EN_IN once in IDLE after reset.

Configuration
REQ-030 SHALL, with AHA_CLK_DIV_CTRL_TIMEOUT_EN defined, go from WAIT to SWITCH once the wait counter reaches TIMEOUT_CYCLES-1 without CLK_EN_IN, and set TIMEOUT_STICKY on that edge.
REQ-031 SHALL, without AHA_CLK_DIV_CTRL_TIMEOUT_EN, wait in WAIT indefinitely, omit the wait counter, and tie TIMEOUT_STICKY to 0.

Verification
REQ-032 SHALL cover: reset, then REQ_DIV=3 accepted, with CLK_EN_IN pulsed 4 cycles later -> DIV_OUT=3 at SWITCH, GEN_RESETn low 1 cycle, ACK 3 cycles after SWITCH, CLK_EN_OUT=0 across SWITCH and SETTLE.
REQ-033 SHALL cover: REQ_DIV equal to the current DIV_OUT -> ACK 2 cycles after acceptance, GEN_RESETn never low, DIV_OUT unchanged.
REQ-034 SHALL cover: REQ_DIV=7 -> DIV_OUT=5 after the sequence completes.
REQ-035 SHALL cover, with the macro defined: CLK_EN_IN held at 0 -> forced SWITCH after 64 WAIT cycles and TIMEOUT_STICKY=1; TIMEOUT_CLR then clears it; TIMEOUT_CLR on the same edge as the set leaves it at 1.
REQ-036 SHALL cover: RESETn asserted during SETTLE -> no ACK, DIV_OUT=RESET_DIV, REQ_READY=1 after release.
REQ-037 SHALL cover: REQ_VALID held during WAIT with a new REQ_DIV -> ignored until IDLE, then accepted.

Source files
------------

// File: rtl/aha_clk_div_ctrl.sv
// aha_clk_div_ctrl: changes the divide code of a clock-enable generator only on an enable
// boundary, restarting the generator and masking enables while it settles.
// Build option: define AHA_CLK_DIV_CTRL_TIMEOUT_EN to bound the wait for an enable boundary.
module aha_clk_div_ctrl #(
   parameter logic [2:0] RESET_DIV      = 3'b000,
   parameter int         SETTLE_CYCLES  = 2,
   parameter int         TIMEOUT_CYCLES = 64
) (
   input  logic       CLK_IN,
   input  logic       RESETn,
   input  logic       REQ_VALID,
   input  logic [2:0] REQ_DIV,
   output logic       REQ_READY,
   output logic       ACK,
   output logic [2:0] DIV_OUT,
   output logic       GEN_RESETn,
   input  logic       CLK_EN_IN,
   output logic       CLK_EN_OUT,
   input  logic       TIMEOUT_CLR,
   output logic       TIMEOUT_STICKY
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WAIT   = 3'd1,
      SWITCH = 3'd2,
      SETTLE = 3'd3,
      DONE   = 3'd4
   } stateT;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   stateT      stateQ, stateD;
   logic [2:0] targetQ, targetD;
   logic [2:0] divQ, divD;
   logic [3:0] settleCntQ, settleCntD;
   logic       genResetNQ;
   logic [2:0] reqDivClamped;
   logic       settleLast;
   logic       enBoundary;

   // Codes above 5 are not supported by the generator, so they saturate at 5.
   assign reqDivClamped = (REQ_DIV > 3'd5) ? 3'd5 : REQ_DIV;
   assign settleLast    = (settleCntQ == SETTLE_LAST);

`ifdef AHA_CLK_DIV_CTRL_TIMEOUT_EN
   localparam logic [5:0] WAIT_LAST = 6'(TIMEOUT_CYCLES - 1);

   logic [5:0] waitCntQ, waitCntD;
   logic       stickyQ, stickyD;
   logic       timeoutHit;

   assign timeoutHit = (stateQ == WAIT) && !CLK_EN_IN && (waitCntQ == WAIT_LAST);
   assign enBoundary = CLK_EN_IN || timeoutHit;

   always_comb begin
      waitCntD = '0;
      if ((stateQ == WAIT) && (stateD == WAIT)) begin
         waitCntD = waitCntQ + 6'd1;
      end
      // A timeout on the same edge as a clear must leave the flag set.
      stickyD = stickyQ;
      if (timeoutHit) begin
         stickyD = 1'b1;
      end else if (TIMEOUT_CLR) begin
         stickyD = 1'b0;
      end
   end

   always_ff @(posedge CLK_IN or negedge RESETn) begin
      if (!RESETn) begin
         waitCntQ <= '0;
         stickyQ  <= 1'b0;
      end else begin
         waitCntQ <= waitCntD;
         stickyQ  <= stickyD;
      end
   end

   assign TIMEOUT_STICKY = stickyQ;
`else
   logic [7:0] unusedTimeoutCfg;

   assign unusedTimeoutCfg = {TIMEOUT_CLR, 7'(TIMEOUT_CYCLES)};
   assign enBoundary       = CLK_EN_IN;
   assign TIMEOUT_STICKY   = 1'b0;
`endif

   always_ff @(posedge CLK_IN or negedge RESETn) begin
      if (!RESETn) begin
         stateQ <= IDLE;
      end else begin
         stateQ <= stateD;
      end
   end

   always_comb begin
      stateD = stateQ;
      case (stateQ)
         IDLE: begin
            if (REQ_VALID) begin
               stateD = (reqDivClamped == divQ) ? DONE : WAIT;
            end
         end
         WAIT: begin
            if (enBoundary) begin
               stateD = SWITCH;
            end
         end
         SWITCH: stateD = SETTLE;
         SETTLE: begin
            if (settleLast) begin
               stateD = DONE;
            end
         end
         DONE:    stateD = IDLE;
         default: stateD = IDLE;
      endcase
   end

   always_comb begin
      REQ_READY  = 1'b0;
      ACK        = 1'b0;
      CLK_EN_OUT = CLK_EN_IN;
      case (stateQ)
         IDLE:    REQ_READY  = 1'b1;
         SWITCH:  CLK_EN_OUT = 1'b0;
         SETTLE:  CLK_EN_OUT = 1'b0;
         DONE:    ACK        = 1'b1;
         default: ;
      endcase
   end

   // The new code reaches the generator only on the boundary edge that starts the restart.
   always_comb begin
      targetD    = targetQ;
      divD       = divQ;
      settleCntD = '0;
      if ((stateQ == IDLE) && REQ_VALID) begin
         targetD = reqDivClamped;
      end
      if ((stateQ == WAIT) && (stateD == SWITCH)) begin
         divD = targetQ;
      end
      if ((stateQ == SETTLE) && !settleLast) begin
         settleCntD = settleCntQ + 4'd1;
      end
   end

   // Restart is registered from next-state so the generator sees a clean one-cycle low.
   always_ff @(posedge CLK_IN or negedge RESETn) begin
      if (!RESETn) begin
         targetQ    <= RESET_DIV;
         divQ       <= RESET_DIV;
         settleCntQ <= '0;
         genResetNQ <= 1'b1;
      end else begin
         targetQ    <= targetD;
         divQ       <= divD;
         settleCntQ <= settleCntD;
         genResetNQ <= (stateD != SWITCH);
      end
   end

   assign DIV_OUT    = divQ;
   assign GEN_RESETn = genResetNQ;

endmodule

// File: tb/tb_aha_clk_div_ctrl.sv
// tb_aha_clk_div_ctrl: table of divide-change requests checked through a scoreboard,
// plus hand sequences for held requests, the enable-wait bound and mid-sequence reset.
module tb_aha_clk_div_ctrl;

   localparam logic [2:0] RESET_DIV  = 3'b000;
   localparam int         SETTLE     = 2;
   localparam int         TIMEOUT    = 64;
   localparam int         ACK_BUDGET = 300;
   localparam int         NUM_VECS   = 7;

   typedef struct {
      logic [2:0] reqDiv;
      int         enDelay;
      logic [2:0] expDiv;
      bit         expChange;
   } vecT;

   typedef struct {
      logic [2:0] div;
      int         latency;
      int         genLow;
      int         divChanges;
      int         masked;
      bit         change;
   } expT;

   logic       CLK_IN;
   logic       RESETn;
   logic       REQ_VALID;
   logic [2:0] REQ_DIV;
   logic       REQ_READY;
   logic       ACK;
   logic [2:0] DIV_OUT;
   logic       GEN_RESETn;
   logic       CLK_EN_IN;
   logic       CLK_EN_OUT;
   logic       TIMEOUT_CLR;
   logic       TIMEOUT_STICKY;

   int   checks = 0;
   int   errors = 0;
   int   cycleCnt = 0;
   int   ackCount = 0;
   int   acceptCycle = 0;
   int   switchCycle = 0;
   int   genLowCnt = 0;
   int   maskedCnt = 0;
   int   leakCnt = 0;
   int   divChangeCnt = 0;
   bit   tracking = 1'b0;
   logic [2:0] prevDiv = '0;
   logic [2:0] divAtSwitch = '0;
   expT  sbQ[$];
   expT  popped;
   vecT  vecs[NUM_VECS];

   aha_clk_div_ctrl #(
      .RESET_DIV     (RESET_DIV),
      .SETTLE_CYCLES (SETTLE),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .CLK_IN        (CLK_IN),
      .RESETn        (RESETn),
      .REQ_VALID     (REQ_VALID),
      .REQ_DIV       (REQ_DIV),
      .REQ_READY     (REQ_READY),
      .ACK           (ACK),
      .DIV_OUT       (DIV_OUT),
      .GEN_RESETn    (GEN_RESETn),
      .CLK_EN_IN     (CLK_EN_IN),
      .CLK_EN_OUT    (CLK_EN_OUT),
      .TIMEOUT_CLR   (TIMEOUT_CLR),
      .TIMEOUT_STICKY(TIMEOUT_STICKY)
   );

   initial CLK_IN = 1'b0;
   always #5 CLK_IN = ~CLK_IN;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Request-to-ACK latency counts the acceptance cycle as cycle 1.
   function automatic int expLatency(input bit change, input int enDelay);
      if (!change) return 2;
`ifdef AHA_CLK_DIV_CTRL_TIMEOUT_EN
      if (enDelay < 0 || enDelay >= TIMEOUT - 1) return TIMEOUT + 3 + SETTLE;
`endif
      return 4 + enDelay + SETTLE;
   endfunction

   // Monitor: tracks one request from acceptance to ACK and scores it against the queue head.
   always @(negedge CLK_IN) begin
      cycleCnt++;
      if (!RESETn) begin
         tracking = 1'b0;
      end else begin
         if (tracking) begin
            if (!GEN_RESETn) begin
               genLowCnt++;
               switchCycle = cycleCnt;
               divAtSwitch = DIV_OUT;
            end
            if (CLK_EN_IN && !CLK_EN_OUT) maskedCnt++;
            if (!CLK_EN_IN && CLK_EN_OUT) leakCnt++;
            if (DIV_OUT != prevDiv) divChangeCnt++;
            prevDiv = DIV_OUT;
         end
         if (ACK) begin
            ackCount++;
            if (sbQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_ack: got ACK=1, expected no ACK (nothing outstanding)");
            end else begin
               popped = sbQ.pop_front();
               checkOutput("ack_div_out", int'(DIV_OUT), int'(popped.div));
               checkOutput("ack_latency", cycleCnt - acceptCycle + 1, popped.latency);
               checkOutput("gen_resetn_low_cycles", genLowCnt, popped.genLow);
               checkOutput("div_out_changes", divChangeCnt, popped.divChanges);
               checkOutput("clk_en_masked_cycles", maskedCnt, popped.masked);
               checkOutput("clk_en_leak_cycles", leakCnt, 0);
               if (popped.change) begin
                  checkOutput("switch_to_ack", cycleCnt - switchCycle, 1 + SETTLE);
                  checkOutput("div_at_switch", int'(divAtSwitch), int'(popped.div));
               end
            end
            tracking = 1'b0;
         end
         if (REQ_VALID && REQ_READY) begin
            acceptCycle  = cycleCnt;
            tracking     = 1'b1;
            genLowCnt    = 0;
            maskedCnt    = 0;
            leakCnt      = 0;
            divChangeCnt = 0;
            prevDiv      = DIV_OUT;
         end
      end
   end

   // Called just after a rising edge; returns just after the edge that follows the ACK cycle.
   task automatic applyStimulus(input logic [2:0] div, input int enDelay, input logic [2:0] expDiv,
                                input bit expChange, input int clrOffset, input bit holdNew,
                                input logic [2:0] newDiv);
      int  n;
      int  k;
      int  startAck;
      bit  done;
      expT e;
      n = 0;
      while (!REQ_READY && n < 100) begin
         @(posedge CLK_IN);
         #1;
         n++;
      end
      checkOutput("req_ready_before_request", int'(REQ_READY), 1);
      REQ_VALID    = 1'b1;
      REQ_DIV      = div;
      e.div        = expDiv;
      e.change     = expChange;
      e.latency    = expLatency(expChange, enDelay);
      e.genLow     = expChange ? 1 : 0;
      e.divChanges = expChange ? 1 : 0;
      e.masked     = (expChange && enDelay >= 0) ? 1 + SETTLE : 0;
      sbQ.push_back(e);
      startAck = ackCount;
      k        = 0;
      done     = 1'b0;
      while (!done && k < ACK_BUDGET) begin
         @(posedge CLK_IN);
         #1;
         k++;
         done        = (ackCount != startAck);
         CLK_EN_IN   = !done && (enDelay >= 0) && (k >= 1 + enDelay);
         TIMEOUT_CLR = !done && (k == clrOffset);
         REQ_VALID   = holdNew;
         if (holdNew) REQ_DIV = newDiv;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("[TB] FAIL ack_timeout: got no ACK in %0d cycles, expected ACK for div %0d",
                  ACK_BUDGET, expDiv);
         if (sbQ.size() > 0) sbQ.delete(sbQ.size() - 1);
      end
   endtask

   initial begin
      int n;
      int ackBefore;
      RESETn      = 1'b1;
      REQ_VALID   = 1'b0;
      REQ_DIV     = 3'd0;
      CLK_EN_IN   = 1'b0;
      TIMEOUT_CLR = 1'b0;

      vecs[0] = '{3'd3, 3,  3'd3, 1'b1};
      vecs[1] = '{3'd3, 0,  3'd3, 1'b0};
      vecs[2] = '{3'd7, 0,  3'd5, 1'b1};
      vecs[3] = '{3'd6, 2,  3'd5, 1'b0};
      vecs[4] = '{3'd1, 5,  3'd1, 1'b1};
      vecs[5] = '{3'd0, 20, 3'd0, 1'b1};
      vecs[6] = '{3'd5, 1,  3'd5, 1'b1};

      #2 RESETn = 1'b0;
      #1;
      checkOutput("reset_req_ready", int'(REQ_READY), 1);
      checkOutput("reset_ack", int'(ACK), 0);
      checkOutput("reset_gen_resetn", int'(GEN_RESETn), 1);
      checkOutput("reset_div_out", int'(DIV_OUT), int'(RESET_DIV));
      checkOutput("reset_timeout_sticky", int'(TIMEOUT_STICKY), 0);
      CLK_EN_IN = 1'b1;
      #1;
      checkOutput("reset_clk_en_follow", int'(CLK_EN_OUT), 1);
      CLK_EN_IN = 1'b0;
      repeat (3) @(posedge CLK_IN);
      #1 RESETn = 1'b1;
      @(posedge CLK_IN);
      #1;

      for (int i = 0; i < NUM_VECS; i++) begin
         applyStimulus(vecs[i].reqDiv, vecs[i].enDelay, vecs[i].expDiv, vecs[i].expChange,
                       -1, 1'b0, 3'd0);
         checkOutput("sticky_after_normal", int'(TIMEOUT_STICKY), 0);
      end

      // A request held through WAIT with a new code is taken only once back in IDLE.
      applyStimulus(3'd2, 4, 3'd2, 1'b1, -1, 1'b1, 3'd6);
      applyStimulus(3'd6, 2, 3'd5, 1'b1, -1, 1'b0, 3'd0);

`ifdef AHA_CLK_DIV_CTRL_TIMEOUT_EN
      applyStimulus(3'd2, -1, 3'd2, 1'b1, -1, 1'b0, 3'd0);
      checkOutput("sticky_set_by_timeout", int'(TIMEOUT_STICKY), 1);
      TIMEOUT_CLR = 1'b1;
      @(posedge CLK_IN);
      #1 TIMEOUT_CLR = 1'b0;
      checkOutput("sticky_cleared", int'(TIMEOUT_STICKY), 0);
      applyStimulus(3'd4, -1, 3'd4, 1'b1, TIMEOUT, 1'b0, 3'd0);
      checkOutput("sticky_set_wins_over_clear", int'(TIMEOUT_STICKY), 1);
      TIMEOUT_CLR = 1'b1;
      @(posedge CLK_IN);
      #1 TIMEOUT_CLR = 1'b0;
      checkOutput("sticky_cleared_again", int'(TIMEOUT_STICKY), 0);
`else
      applyStimulus(3'd2, 80, 3'd2, 1'b1, -1, 1'b0, 3'd0);
      checkOutput("sticky_tied_low", int'(TIMEOUT_STICKY), 0);
`endif

      // Reset during SETTLE abandons the change without an ACK.
      ackBefore = ackCount;
      n = 0;
      while (!REQ_READY && n < 100) begin
         @(posedge CLK_IN);
         #1;
         n++;
      end
      REQ_VALID = 1'b1;
      REQ_DIV   = 3'd1;
      @(posedge CLK_IN);
      #1;
      REQ_VALID = 1'b0;
      CLK_EN_IN = 1'b1;
      checkOutput("wait_req_ready", int'(REQ_READY), 0);
      @(posedge CLK_IN);
      #1;
      checkOutput("switch_gen_resetn", int'(GEN_RESETn), 0);
      checkOutput("switch_div_out", int'(DIV_OUT), 1);
      checkOutput("switch_clk_en_mask", int'(CLK_EN_OUT), 0);
      @(posedge CLK_IN);
      #1;
      checkOutput("settle_clk_en_mask", int'(CLK_EN_OUT), 0);
      RESETn = 1'b0;
      #1;
      checkOutput("midreset_div_out", int'(DIV_OUT), int'(RESET_DIV));
      checkOutput("midreset_req_ready", int'(REQ_READY), 1);
      checkOutput("midreset_gen_resetn", int'(GEN_RESETn), 1);
      checkOutput("midreset_ack", int'(ACK), 0);
      repeat (2) @(posedge CLK_IN);
      #1 RESETn = 1'b1;
      repeat (6) @(posedge CLK_IN);
      #1;
      checkOutput("midreset_no_ack", ackCount - ackBefore, 0);
      checkOutput("post_reset_req_ready", int'(REQ_READY), 1);
      checkOutput("post_reset_div_out", int'(DIV_OUT), int'(RESET_DIV));
      checkOutput("post_reset_clk_en_follow", int'(CLK_EN_OUT), 1);
      CLK_EN_IN = 1'b0;

      checkOutput("scoreboard_drained", sbQ.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got no end of test by 1 ms, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
